// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared encodings for the control sequencer
//
// Purpose: opcode values, FSM state encoding, ALU function codes, instruction
// classes, write-back source select and instruction field bit positions used
// by seq_decoder and control_sequencer.
// Ports: none (package).

package seq_pkg;

  localparam int INSTR_WIDTH = 16;
  localparam int OPCODE_WIDTH = 4;

  // Instruction field positions
  localparam int OPCODE_MSB = 15;
  localparam int OPCODE_LSB = 12;
  localparam int RD_MSB     = 11;
  localparam int RD_LSB     = 9;
  localparam int RA_MSB     = 8;
  localparam int RA_LSB     = 6;
  localparam int RB_MSB     = 5;
  localparam int RB_LSB     = 3;
  localparam int IMM_MSB    = 7;
  localparam int IMM_LSB    = 0;

  // Opcodes
  localparam logic [OPCODE_WIDTH-1:0] OP_NOP  = 4'h0;
  localparam logic [OPCODE_WIDTH-1:0] OP_ADD  = 4'h1;
  localparam logic [OPCODE_WIDTH-1:0] OP_SUB  = 4'h2;
  localparam logic [OPCODE_WIDTH-1:0] OP_AND  = 4'h3;
  localparam logic [OPCODE_WIDTH-1:0] OP_OR   = 4'h4;
  localparam logic [OPCODE_WIDTH-1:0] OP_XOR  = 4'h5;
  localparam logic [OPCODE_WIDTH-1:0] OP_MOV  = 4'h6;
  localparam logic [OPCODE_WIDTH-1:0] OP_LDI  = 4'h7;
  localparam logic [OPCODE_WIDTH-1:0] OP_JMP  = 4'h8;
  localparam logic [OPCODE_WIDTH-1:0] OP_BZ   = 4'h9;
  localparam logic [OPCODE_WIDTH-1:0] OP_HALT = 4'hF;

  typedef enum logic [2:0] {
    ST_RST       = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_EXECUTE   = 3'd3,
    ST_WRITEBACK = 3'd4,
    ST_HALT      = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    ALU_ADD    = 3'd0,
    ALU_SUB    = 3'd1,
    ALU_AND    = 3'd2,
    ALU_OR     = 3'd3,
    ALU_XOR    = 3'd4,
    ALU_PASS_A = 3'd5
  } alu_op_t;

  typedef enum logic [2:0] {
    CLS_NOP     = 3'd0,
    CLS_ALU     = 3'd1,
    CLS_LDI     = 3'd2,
    CLS_BRANCH  = 3'd3,
    CLS_HALT    = 3'd4,
    CLS_ILLEGAL = 3'd5
  } instr_class_t;

  typedef enum logic {
    WB_RESULT = 1'b0,
    WB_IMM    = 1'b1
  } wb_sel_t;

  function automatic logic [OPCODE_WIDTH-1:0] ir_opcode(input logic [INSTR_WIDTH-1:0] ir);
    return ir[OPCODE_MSB:OPCODE_LSB];
  endfunction

endpackage

// File: rtl/seq_decoder.sv
// rtl/seq_decoder.sv - combinational opcode decoder for the control sequencer
//
// Purpose: maps the instruction opcode to an ALU function, an instruction
// class and the write-back data source.
// Build option: SEQ_BRANCH_EN - when defined JMP/BZ decode as CLS_BRANCH,
// otherwise opcodes 8/9 decode as CLS_ILLEGAL.
// Ports:
//   opcode      in  4  instruction bits [15:12]
//   alu_op      out 3  ALU function for ALU/MOV instructions (ADD otherwise)
//   instr_class out 3  nop/alu/ldi/branch/halt/illegal
//   wb_sel      out 1  write-back source: ALU result or immediate

import seq_pkg::*;

module seq_decoder (
  input  logic [OPCODE_WIDTH-1:0] opcode,
  output alu_op_t                 alu_op,
  output instr_class_t            instr_class,
  output wb_sel_t                 wb_sel
);

  always_comb begin
    alu_op      = ALU_ADD;
    instr_class = CLS_ILLEGAL;
    wb_sel      = WB_RESULT;
    case (opcode)
      OP_NOP:  instr_class = CLS_NOP;
      OP_ADD: begin
        instr_class = CLS_ALU;
        alu_op      = ALU_ADD;
      end
      OP_SUB: begin
        instr_class = CLS_ALU;
        alu_op      = ALU_SUB;
      end
      OP_AND: begin
        instr_class = CLS_ALU;
        alu_op      = ALU_AND;
      end
      OP_OR: begin
        instr_class = CLS_ALU;
        alu_op      = ALU_OR;
      end
      OP_XOR: begin
        instr_class = CLS_ALU;
        alu_op      = ALU_XOR;
      end
      // MOV goes through the ALU so it shares the result/Z path
      OP_MOV: begin
        instr_class = CLS_ALU;
        alu_op      = ALU_PASS_A;
      end
      OP_LDI: begin
        instr_class = CLS_LDI;
        wb_sel      = WB_IMM;
      end
`ifdef SEQ_BRANCH_EN
      OP_JMP,
      OP_BZ:   instr_class = CLS_BRANCH;
`endif
      OP_HALT: instr_class = CLS_HALT;
      default: instr_class = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - fetch/decode/execute controller of the 8-bit MCU
//
// Purpose: fetches 16-bit instructions over a req/ack port, drives the
// register-file addresses, write strobe and write data, and selects the ALU
// function. Write-back data is either the captured ALU result or IR[7:0].
// Build option: SEQ_BRANCH_EN - enables JMP/BZ; without it opcodes 8/9 are
// illegal (the PC keeps its fetch increment).
// Ports:
//   clk, rst           clock (rising edge), asynchronous active-low reset
//   imem_req/addr      fetch request and address (PC), held until ack
//   imem_ack/data      fetch acknowledge and instruction word
//   rf_addrA/rf_addrB  read selects IR[8:6] / IR[5:3]
//   rf_write_addr      write select IR[11:9]
//   rf_write_enable    one-cycle write strobe (WRITEBACK)
//   rf_data_in         write data
//   alu_op             ALU function, alu_result = combinational ALU output
//   halted             high from HALT until reset
//   illegal            one-cycle pulse on an undefined opcode

import seq_pkg::*;

module control_sequencer #(
  parameter int ADDRESS_WIDTH = 3,
  parameter int BUS_WIDTH     = 8,
  parameter int PC_WIDTH      = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     imem_req,
  output logic [PC_WIDTH-1:0]      imem_addr,
  input  logic                     imem_ack,
  input  logic [INSTR_WIDTH-1:0]   imem_data,
  output logic [ADDRESS_WIDTH-1:0] rf_addrA,
  output logic [ADDRESS_WIDTH-1:0] rf_addrB,
  output logic [ADDRESS_WIDTH-1:0] rf_write_addr,
  output logic                     rf_write_enable,
  output logic [BUS_WIDTH-1:0]     rf_data_in,
  output logic [2:0]               alu_op,
  input  logic [BUS_WIDTH-1:0]     alu_result,
  output logic                     halted,
  output logic                     illegal
);

  state_t                   state, state_d;
  logic [PC_WIDTH-1:0]      pc, pc_d;
  logic [INSTR_WIDTH-1:0]   ir, ir_d;
  logic                     z, z_d;
  logic [BUS_WIDTH-1:0]     result, result_d;

  alu_op_t                  dec_alu_op;
  instr_class_t             dec_class;
  wb_sel_t                  dec_wb_sel;
  logic [7:0]               imm8;

  seq_decoder u_decoder (
    .opcode      (ir_opcode(ir)),
    .alu_op      (dec_alu_op),
    .instr_class (dec_class),
    .wb_sel      (dec_wb_sel)
  );

  assign imm8 = ir[IMM_MSB:IMM_LSB];

  // Everything below is decoded from registered state so the async reset
  // clears all outputs immediately (IR=0 decodes as NOP/ADD/result).
  assign imem_req        = (state == ST_FETCH);
  assign imem_addr       = pc;
  assign rf_addrA        = ADDRESS_WIDTH'(ir[RA_MSB:RA_LSB]);
  assign rf_addrB        = ADDRESS_WIDTH'(ir[RB_MSB:RB_LSB]);
  assign rf_write_addr   = ADDRESS_WIDTH'(ir[RD_MSB:RD_LSB]);
  assign rf_write_enable = (state == ST_WRITEBACK);
  assign rf_data_in      = (dec_wb_sel == WB_IMM) ? BUS_WIDTH'(imm8) : result;
  assign alu_op          = dec_alu_op;
  assign halted          = (state == ST_HALT);
  assign illegal         = (state == ST_DECODE) && (dec_class == CLS_ILLEGAL);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= ST_RST;
      pc     <= '0;
      ir     <= '0;
      z      <= 1'b0;
      result <= '0;
    end else begin
      state  <= state_d;
      pc     <= pc_d;
      ir     <= ir_d;
      z      <= z_d;
      result <= result_d;
    end
  end

  always_comb begin
    state_d  = state;
    pc_d     = pc;
    ir_d     = ir;
    z_d      = z;
    result_d = result;
    case (state)
      ST_RST: state_d = ST_FETCH;

      ST_FETCH: begin
        if (imem_ack) begin
          ir_d    = imem_data;
          pc_d    = pc + PC_WIDTH'(1);
          state_d = ST_DECODE;
        end
      end

      ST_DECODE: begin
        case (dec_class)
          CLS_ALU:    state_d = ST_EXECUTE;
          CLS_LDI:    state_d = ST_WRITEBACK;
          CLS_BRANCH: begin
            // PC already holds the fall-through address from FETCH
            if ((ir_opcode(ir) == OP_JMP) || z) begin
              pc_d = PC_WIDTH'(imm8);
            end
            state_d = ST_FETCH;
          end
          CLS_HALT:   state_d = ST_HALT;
          default:    state_d = ST_FETCH;
        endcase
      end

      // Register-file reads complete here, before the WRITEBACK edge, so
      // rd may equal ra/rb.
      ST_EXECUTE: begin
        result_d = alu_result;
        z_d      = (alu_result == '0);
        state_d  = ST_WRITEBACK;
      end

      ST_WRITEBACK: state_d = ST_FETCH;

      ST_HALT: state_d = ST_HALT;

      default: state_d = ST_RST;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - self-checking bench for control_sequencer

module tb_control_sequencer;

`ifdef SEQ_BRANCH_EN
  localparam bit BR_EN = 1'b1;
`else
  localparam bit BR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack = 1'b0;
  logic [15:0] imem_data = 16'h0000;
  logic [2:0]  rf_addrA, rf_addrB, rf_write_addr;
  logic        rf_write_enable;
  logic [7:0]  rf_data_in;
  logic [2:0]  alu_op;
  logic [7:0]  alu_result;
  logic        halted, illegal;

  control_sequencer #(.ADDRESS_WIDTH(3), .BUS_WIDTH(8), .PC_WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
    .rf_addrA(rf_addrA), .rf_addrB(rf_addrB), .rf_write_addr(rf_write_addr),
    .rf_write_enable(rf_write_enable), .rf_data_in(rf_data_in),
    .alu_op(alu_op), .alu_result(alu_result), .halted(halted), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // Environment: instruction memory, register file, ALU
  logic [15:0] imem [256];
  logic [7:0]  rf_env [8];

  always_comb begin
    case (alu_op)
      3'd0:    alu_result = rf_env[rf_addrA] + rf_env[rf_addrB];
      3'd1:    alu_result = rf_env[rf_addrA] - rf_env[rf_addrB];
      3'd2:    alu_result = rf_env[rf_addrA] & rf_env[rf_addrB];
      3'd3:    alu_result = rf_env[rf_addrA] | rf_env[rf_addrB];
      3'd4:    alu_result = rf_env[rf_addrA] ^ rf_env[rf_addrB];
      3'd5:    alu_result = rf_env[rf_addrA];
      default: alu_result = 8'h00;
    endcase
  end

  // Instruction-level reference model
  logic [7:0] m_regs [8];
  logic [7:0] m_pc;
  bit         m_z;
  int         exp_req_at, exp_wr_at, exp_ill_at, exp_halt_at;
  logic [2:0] exp_wr_addr;
  logic [7:0] exp_wr_data;

  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  bit  prev_req;
  int  wait_cnt;
  int  fixed_wait;
  bit  saw_wr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  function automatic int next_wait();
    if (fixed_wait >= 0) return fixed_wait;
    return int'($urandom_range(3, 0));
  endfunction

  // Applies one instruction fetched during bench cycle c.
  task automatic model_exec(input logic [15:0] instr, input int c);
    logic [3:0] op;
    logic [2:0] rd, ra, rb;
    logic [7:0] imm, a, b, res;
    op  = instr[15:12];
    rd  = instr[11:9];
    ra  = instr[8:6];
    rb  = instr[5:3];
    imm = instr[7:0];
    a   = m_regs[ra];
    b   = m_regs[rb];
    m_pc = m_pc + 8'd1;
    exp_req_at = c + 2;
    case (op)
      4'h0: ;
      4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6: begin
        case (op)
          4'h1:    res = a + b;
          4'h2:    res = a - b;
          4'h3:    res = a & b;
          4'h4:    res = a | b;
          4'h5:    res = a ^ b;
          default: res = a;
        endcase
        m_regs[rd]  = res;
        m_z         = (res == 8'd0);
        exp_wr_at   = c + 3;
        exp_wr_addr = rd;
        exp_wr_data = res;
        exp_req_at  = c + 4;
      end
      4'h7: begin
        m_regs[rd]  = imm;
        exp_wr_at   = c + 2;
        exp_wr_addr = rd;
        exp_wr_data = imm;
        exp_req_at  = c + 3;
      end
      4'h8: if (BR_EN) m_pc = imm; else exp_ill_at = c + 1;
      4'h9: if (BR_EN) begin
              if (m_z) m_pc = imm;
            end else exp_ill_at = c + 1;
      4'hF: begin
        exp_halt_at = c + 2;
        exp_req_at  = -1;
      end
      default: exp_ill_at = c + 1;
    endcase
  endtask

  // One clock: sample outputs at the falling edge, drive inputs for the next rise.
  task automatic step();
    @(negedge clk);
    cyc++;
    saw_wr = 1'b0;

    if (imem_req && !prev_req) check("req_cycle", 32'(cyc), 32'(exp_req_at));
    else if (!imem_req && cyc == exp_req_at) check("req_missing", 32'(imem_req), 32'd1);
    if (imem_req) check("imem_addr", 32'(imem_addr), 32'(m_pc));

    if (rf_write_enable || cyc == exp_wr_at) begin
      check("wr_en", 32'(rf_write_enable), 32'(cyc == exp_wr_at));
      if (rf_write_enable && cyc == exp_wr_at) begin
        check("wr_addr", 32'(rf_write_addr), 32'(exp_wr_addr));
        check("wr_data", 32'(rf_data_in), 32'(exp_wr_data));
      end
    end
    if (rf_write_enable) begin
      rf_env[rf_write_addr] = rf_data_in;
      saw_wr = 1'b1;
    end

    if (illegal || cyc == exp_ill_at) check("illegal", 32'(illegal), 32'(cyc == exp_ill_at));
    if (halted || (exp_halt_at >= 0 && cyc >= exp_halt_at))
      check("halted", 32'(halted), 32'(exp_halt_at >= 0 && cyc >= exp_halt_at));

    prev_req = imem_req;
    if (imem_req && wait_cnt == 0) begin
      imem_ack  = 1'b1;
      imem_data = imem[imem_addr];
      model_exec(imem[m_pc], cyc);
      wait_cnt = next_wait();
    end else begin
      imem_ack  = 1'b0;
      imem_data = 16'($urandom);
      if (imem_req) wait_cnt--;
    end
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    imem_ack  = 1'b1;          // stray ack while in reset must be ignored
    imem_data = 16'hF000;
    repeat (3) @(negedge clk);
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_addr", 32'(imem_addr), 32'd0);
    check("rst_we", 32'(rf_write_enable), 32'd0);
    check("rst_data", 32'(rf_data_in), 32'd0);
    check("rst_rfaddr", 32'({rf_addrA, rf_addrB, rf_write_addr}), 32'd0);
    check("rst_aluop", 32'(alu_op), 32'd0);
    check("rst_flags", 32'({halted, illegal}), 32'd0);
    for (int i = 0; i < 8; i++) begin
      rf_env[i] = 8'h00;
      m_regs[i] = 8'h00;
    end
    m_pc = 8'h00;
    m_z = 1'b0;
    exp_req_at = cyc + 1;
    exp_wr_at = -1;
    exp_ill_at = -1;
    exp_halt_at = -1;
    prev_req = 1'b0;
    wait_cnt = next_wait();
    imem_ack = 1'b0;
    rst = 1'b1;
  endtask

  task automatic load_prog_a();
    for (int i = 0; i < 256; i++) imem[i] = 16'h0000;
    imem[8'h00] = 16'h7205;    // LDI R1,0x05
    imem[8'h01] = 16'h7403;    // LDI R2,0x03
    imem[8'h02] = 16'h1650;    // ADD R3,R1,R2
    imem[8'h03] = 16'h2848;    // SUB R4,R1,R1
    imem[8'h04] = 16'h9040;    // BZ 0x40
    imem[8'h10] = 16'hE000;    // undefined opcode
    imem[8'h40] = 16'h2A50;    // SUB R5,R1,R2 (nonzero)
    imem[8'h41] = 16'h9080;    // BZ 0x80 (not taken)
    imem[8'h42] = 16'h80FF;    // JMP 0xFF
    imem[8'hFF] = 16'h0000;    // NOP, PC wraps to 0x00
  endtask

  task automatic load_prog_b();
    for (int i = 0; i < 256; i++) imem[i] = 16'h0000;
    imem[8'h00] = 16'h8010;    // JMP 0x10
    imem[8'h10] = 16'hE000;    // undefined opcode at 0x10
    imem[8'h11] = 16'hF000;    // HALT
  endtask

  initial begin
    int n;
    logic [3:0] op;

    // Directed program, zero-wait fetches
    fixed_wait = 0;
    load_prog_a();
    do_reset();
    run(600);
    check("r3_add", 32'(rf_env[3]), 32'h08);
    check("r4_sub", 32'(rf_env[4]), 32'h00);

    // Same program with three wait cycles per fetch
    fixed_wait = 3;
    do_reset();
    run(400);
    check("r3_add_slow", 32'(rf_env[3]), 32'h08);

    // Illegal opcode then HALT; sequencer must stay idle afterwards
    fixed_wait = 0;
    load_prog_b();
    do_reset();
    run(90);
    check("halted_end", 32'(halted), 32'd1);

    // Reset asserted during WRITEBACK
    load_prog_a();
    do_reset();
    n = 0;
    while (!saw_wr && n < 50) begin
      step();
      n++;
    end
    check("wb_seen", 32'(saw_wr), 32'd1);
    #1 rst = 1'b0;
    #1;
    check("wb_rst_we", 32'(rf_write_enable), 32'd0);
    check("wb_rst_pc", 32'(imem_addr), 32'd0);
    check("wb_rst_req", 32'(imem_req), 32'd0);

    // Random programs with random fetch latency
    fixed_wait = -1;
    for (int s = 0; s < 4; s++) begin
      for (int i = 0; i < 256; i++) begin
        op = 4'($urandom_range(15, 0));
        if (op == 4'hF && $urandom_range(7, 0) != 0) op = 4'h7;
        imem[i] = {op, 12'($urandom)};
      end
      do_reset();
      run(2000);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
